// File: rtl/prio_grant_arbiter_if.sv
// prio_grant_arbiter_if: request/grant bundle between four clients and the arbiter.
interface prio_grant_arbiter_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       expired;
  modport master (output req, input gnt, gnt_id, busy, expired);
  modport slave  (input req, output gnt, gnt_id, busy, expired);
endinterface

// File: rtl/prio_grant_arbiter.sv
// prio_grant_arbiter: 4-client arbiter with hold timer, timeout mask and one idle cycle between owners.
// Define PRIO_GRANT_ARB_RR_EN for rotating priority; otherwise fixed 3>2>1>0.
module prio_grant_arbiter #(
  parameter int MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  prio_grant_arbiter_if.slave  bus
);
  localparam int CW = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0] mask, mask_nx, gnt_q, gnt_nx, elig;
  logic [1:0] id_q, id_nx, start, win;
  logic found, busy_q, exp_q, exp_nx;
  assign elig = bus.req & ~mask;
`ifdef PRIO_GRANT_ARB_RR_EN
  logic [1:0] ptr;
  assign start = ptr - 2'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (state == IDLE && found) ptr <= win;
`else
  assign start = 2'd3;
`endif
  // search downward from start with wrap; first eligible client wins
  always_comb begin
    found = 1'b0;
    win = 2'd0;
    for (int i = 0; i < 4; i++)
      if (!found && elig[start - 2'(i)]) begin
        found = 1'b1;
        win = start - 2'(i);
      end
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    mask_nx = mask;
    gnt_nx = gnt_q;
    id_nx = id_q;
    exp_nx = 1'b0;
    if (state == IDLE) begin
      mask_nx = '0;
      state_nx = found ? BUSY : IDLE;
      gnt_nx = found ? 4'b0001 << win : 4'b0000;
      id_nx = found ? win : 2'd0;
      cnt_nx = '0;
    end else if (!bus.req[id_q]) begin
      state_nx = IDLE;
      gnt_nx = '0;
      id_nx = '0;
    end else if (cnt == CW'(MAX_HOLD - 1)) begin
      state_nx = IDLE;
      gnt_nx = '0;
      id_nx = '0;
      exp_nx = 1'b1;
      mask_nx = 4'b0001 << id_q;
    end else begin
      cnt_nx = cnt + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mask <= '0;
      gnt_q <= '0;
      id_q <= '0;
      busy_q <= 1'b0;
      exp_q <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      mask <= mask_nx;
      gnt_q <= gnt_nx;
      id_q <= id_nx;
      busy_q <= |gnt_nx;
      exp_q <= exp_nx;
    end
  assign bus.gnt = gnt_q;
  assign bus.gnt_id = id_q;
  assign bus.busy = busy_q;
  assign bus.expired = exp_q;
endmodule

// File: tb/tb_prio_grant_arbiter.sv
// tb_prio_grant_arbiter: directed checks of grant, release, timeout, mask and priority order.
module tb_prio_grant_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  prio_grant_arbiter_if if4 ();
  prio_grant_arbiter_if if2 ();
  prio_grant_arbiter_if if3 ();
  prio_grant_arbiter #(.MAX_HOLD(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  prio_grant_arbiter #(.MAX_HOLD(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  prio_grant_arbiter #(.MAX_HOLD(3)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3));
  always #5 clk = ~clk;
`ifdef PRIO_GRANT_ARB_RR_EN
  int seq [5] = '{3, 2, 1, 0, 3};
`else
  int seq [5] = '{3, 3, 3, 3, 3};
`endif
  function automatic logic [7:0] e(input logic [3:0] g, input logic x);
    logic [1:0] id;
    id = g[3] ? 2'd3 : g[2] ? 2'd2 : g[1] ? 2'd1 : 2'd0;
    return {x, |g, id, g};
  endfunction
  function automatic logic [7:0] o4();
    return {if4.expired, if4.busy, if4.gnt_id, if4.gnt};
  endfunction
  function automatic logic [7:0] o2();
    return {if2.expired, if2.busy, if2.gnt_id, if2.gnt};
  endfunction
  function automatic logic [7:0] o3();
    return {if3.expired, if3.busy, if3.gnt_id, if3.gnt};
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    if4.req = '0;
    if2.req = '0;
    if3.req = '0;
    #3;
    chk("reset4", o4(), 8'h00);
    chk("reset2", o2(), 8'h00);
    tick();
    tick();
    rst_n = 1'b1;
    // fixed priority then release with one-cycle gap
    if4.req = 4'b0110;
    tick(); chk("fp_grant", o4(), e(4'b0100, 0));
    if4.req = 4'b0010;
    tick(); chk("fp_gap", o4(), e(4'b0000, 0));
    tick(); chk("fp_next", o4(), e(4'b0010, 0));
    if4.req = '0;
    tick(); chk("fp_release", o4(), e(4'b0000, 0));
    tick();
    // asynchronous reset during a grant
    if4.req = 4'b0100;
    tick(); chk("pre_rst", o4(), e(4'b0100, 0));
    rst_n = 1'b0;
    #1; chk("rst_async", o4(), 8'h00);
    if4.req = 4'b0110;
    tick(); chk("rst_hold", o4(), 8'h00);
    rst_n = 1'b1;
    tick(); chk("post_rst", o4(), e(4'b0100, 0));
    if4.req = '0;
    tick();
    tick();
    // timeout with MAX_HOLD=4 and masking of the expired owner
    if4.req = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("to_hold3", o4(), e(4'b1000, 0));
    end
    tick(); chk("to_exp3", o4(), e(4'b0000, 1));
    for (int k = 0; k < 4; k++) begin
      tick(); chk("to_hold0", o4(), e(4'b0001, 0));
    end
    tick(); chk("to_exp0", o4(), e(4'b0000, 1));
    tick(); chk("to_c3", o4(), e(4'b1000, 0));
    if4.req = '0;
    tick(); chk("to_release", o4(), e(4'b0000, 0));
    tick();
    // lone masked requester, MAX_HOLD=2
    if2.req = 4'b0100;
    for (int r = 0; r < 2; r++) begin
      tick(); chk("lone_g1", o2(), e(4'b0100, 0));
      tick(); chk("lone_g2", o2(), e(4'b0100, 0));
      tick(); chk("lone_exp", o2(), e(4'b0000, 1));
      tick(); chk("lone_mask", o2(), e(4'b0000, 0));
    end
    if2.req = '0;
    tick();
    tick();
    // release exactly at the expiry boundary, MAX_HOLD=3
    if3.req = 4'b0010;
    tick(); chk("bd_c0", o3(), e(4'b0010, 0));
    tick(); chk("bd_c1", o3(), e(4'b0010, 0));
    tick(); chk("bd_c2", o3(), e(4'b0010, 0));
    if3.req = '0;
    tick(); chk("bd_noexp", o3(), e(4'b0000, 0));
    if3.req = 4'b0010;
    tick(); chk("bd_nomask", o3(), e(4'b0010, 0));
    tick(); chk("bd_h1", o3(), e(4'b0010, 0));
    tick(); chk("bd_h2", o3(), e(4'b0010, 0));
    tick(); chk("bd_exp", o3(), e(4'b0000, 1));
    if3.req = '0;
    tick();
    tick();
    // all four requesting, each owner releases after one cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    if4.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(); chk("seq_grant", o4(), e(4'b0001 << seq[k], 0));
      if4.req = 4'b1111 & ~(4'b0001 << seq[k]);
      tick(); chk("seq_gap", o4(), e(4'b0000, 0));
      if4.req = 4'b1111;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/prio_grant_arbiter.md
# prio_grant_arbiter

Sequential 4-requester arbiter sharing a single downstream resource (bus port, encoder lane, shared register bank) among four clients. It picks a winner from a 4-bit request vector using the team's standard priority order: bit 3 highest, bit 0 lowest. It holds the grant until the owner releases its request or a hold timer expires, and inserts one idle cycle between owners. It sits between the client request lines and the shared resource's select/enable.

## Interface
- MAX_HOLD, 16: maximum consecutive cycles one owner keeps the grant; legal range 1..255.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  4  request vector; client k holds req[k] high for as long as it needs the resource.
- gnt  output  4  one-hot grant, registered; all zero when no owner.
- gnt_id  output  2  binary index of current owner; 0 when gnt is 0.
- busy  output  1  high while any grant is active (equals |gnt).
- expired  output  1  one-cycle pulse when an owner's grant is revoked by the hold timer.

## Operation
- States:
  - IDLE: no owner.
  - BUSY: owner latched.
- Reset (async, immediate):
  - state=IDLE; gnt=0, gnt_id=0, busy=0, expired=0.
  - hold counter=0, mask=0, rotation pointer=0.
- IDLE, arbitration on each edge:
  - Eligible set is req & ~mask.
  - If the eligible set is non-zero: latch the winner, drive gnt/gnt_id from the winner, clear the hold counter, go to BUSY.
  - If the eligible set is zero: stay in IDLE.
  - mask clears on every IDLE edge, whether or not a grant is made.
- BUSY, per edge:
  - If req[owner]==0: normal release. Go to IDLE, gnt=0.
  - Else if hold counter == MAX_HOLD-1: timeout. Go to IDLE, gnt=0, pulse expired for one cycle, set mask bit of the owner.
  - Else: increment the hold counter and stay in BUSY.
- Requests from non-owners during BUSY are ignored; they are arbitrated only in IDLE.
- Changes on req[k] for k≠owner never disturb gnt.
- Hold counter width is clog2(MAX_HOLD+1). The counter never wraps; the timeout check precedes the increment.
- The owner dropping req in the same cycle the timer would expire counts as a normal release: expired stays 0 and no mask is set.
- A masked client that is the only requester gets no grant in that IDLE cycle; it wins on the following edge.

## Timing
- Grant latency: req sampled high in IDLE at edge t → gnt visible after edge t (1 cycle from request).
- Release latency: req[owner] sampled low at edge t → gnt=0 after edge t.
- Minimum gap between successive owners: exactly 1 cycle with gnt=0.
- Maximum continuous grant: MAX_HOLD cycles.
- Back-to-back re-grant to the same client after normal release: possible after the 1-cycle gap if it re-asserts req.
- All outputs are registered; there are no combinational paths from req to any output.

## Configuration
- PRIO_GRANT_ARB_RR_EN defined: rotating priority.
  - Search order starts at pointer-1 and goes downward with wrap; after the last index comes 3.
  - Example: after owner 2, the order is 1,0,3,2.
  - The pointer loads the owner index on each grant.
  - Pointer reset is 0, so the first arbitration order is 3,2,1,0, identical to fixed priority.
- Undefined: fixed priority 3>2>1>0 on every arbitration; no pointer register.
- The mask, timeout and idle-gap behaviour is identical in both builds.

## Test plan
- Reset mid-grant: owner 2 active; pulse rst_n low → gnt=0, gnt_id=0, busy=0, expired=0 immediately while rst_n is low; first grant after reset follows fixed order.
- Fixed priority, req=4'b0110 from IDLE → next cycle gnt=4'b0100, gnt_id=2. Drop req[2] → one cycle gnt=0, then gnt=4'b0010.
- Timeout, MAX_HOLD=4, req=4'b1001 held constant:
  - gnt=4'b1000 for exactly 4 cycles, then expired=1 and gnt=0 for 1 cycle, then gnt=4'b0001 (client 3 masked).
  - When client 0 later times out, client 3 is granted next.
- Lone masked requester, MAX_HOLD=2, req=4'b0100 constant → pattern 2 cycles gnt=4'b0100, 1 cycle expired with gnt=0, 1 cycle gnt=0 (masked), then re-grant; the pattern repeats.
- Release at the expiry boundary, MAX_HOLD=3: owner drops req on the cycle the counter reaches 2 → expired stays 0 and no mask is set.
- With PRIO_GRANT_ARB_RR_EN, all four requesting continuously, owners release after 1 cycle → grant sequence 3,2,1,0,3,…; without the macro, the sequence is 3,3,3,….
